// File: rtl/ysyx_22040175_pipe_ctrl.sv
// In-order pipeline controller: writer scoreboard, forwarding selects,
// load-use stall, EX redirect, memory-busy freeze and perf counters.
module ysyx_22040175_pipe_ctrl #(
    parameter int NSTAGE     = 3,
    parameter int LOAD_STAGE = 1,
    parameter int RADDR_W    = 5,
    parameter int PC_W       = 64,
    parameter int CNT_W      = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        id_valid,
    input  logic [RADDR_W-1:0]          id_rs1,
    input  logic [RADDR_W-1:0]          id_rs2,
    input  logic                        id_rs1_used,
    input  logic                        id_rs2_used,
    input  logic [RADDR_W-1:0]          id_rd,
    input  logic                        id_wen,
    input  logic                        id_is_load,
    input  logic                        ex_redirect,
    input  logic [PC_W-1:0]             ex_target,
    input  logic                        mem_busy,
    output logic                        pc_hold,
    output logic                        if_id_hold,
    output logic                        if_id_flush,
    output logic                        id_ex_bubble,
    output logic                        pc_sel,
    output logic [PC_W-1:0]             redirect_pc,
    output logic [$clog2(NSTAGE+1)-1:0] fwd_rs1,
    output logic [$clog2(NSTAGE+1)-1:0] fwd_rs2,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            flush_cnt
);

    localparam int FW = $clog2(NSTAGE + 1);

    typedef struct packed {
        logic               v;
        logic [RADDR_W-1:0] rd;
        logic               wen;
        logic               ld;
    } entry_t;

    entry_t [NSTAGE-1:0] sb_q;
    entry_t [NSTAGE-1:0] sb_d;
    logic [CNT_W-1:0]    stall_cnt_q;
    logic [CNT_W-1:0]    stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q;
    logic [CNT_W-1:0]    flush_cnt_d;

    logic [FW-1:0] fwd1;
    logic [FW-1:0] fwd2;
    logic          luse1;
    logic          luse2;
    logic          redirect;
    logic          stall;

    function automatic logic hit(
        input entry_t             e,
        input logic [RADDR_W-1:0] rs,
        input logic               used
    );
        return e.v && e.wen && (e.rd != '0) && (e.rd == rs) && used;
    endfunction

    // Walk oldest to youngest so the lowest matching index wins.
    always_comb begin
        fwd1  = '0;
        fwd2  = '0;
        luse1 = 1'b0;
        luse2 = 1'b0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (hit(sb_q[k], id_rs1, id_rs1_used)) begin
                fwd1  = FW'(k + 1);
                luse1 = sb_q[k].ld && (k < LOAD_STAGE);
            end
            if (hit(sb_q[k], id_rs2, id_rs2_used)) begin
                fwd2  = FW'(k + 1);
                luse2 = sb_q[k].ld && (k < LOAD_STAGE);
            end
        end
    end

    assign redirect = ex_redirect && sb_q[0].v && !mem_busy;
    assign stall    = (luse1 || luse2) && !redirect && !mem_busy;

    assign pc_hold      = mem_busy || stall;
    assign if_id_hold   = mem_busy || stall;
    assign if_id_flush  = redirect;
    assign pc_sel       = redirect;
    assign id_ex_bubble = redirect || stall;
    assign redirect_pc  = ex_target;
    assign fwd_rs1      = fwd1;
    assign fwd_rs2      = fwd2;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

    always_comb begin
        sb_d        = sb_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!mem_busy) begin
            for (int k = NSTAGE - 1; k >= 1; k--) begin
                sb_d[k] = sb_q[k-1];
            end
            sb_d[0].v   = id_valid && !(stall || redirect);
            sb_d[0].rd  = id_rd;
            sb_d[0].wen = id_wen;
            sb_d[0].ld  = id_is_load;
        end
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (redirect && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22040175_pipe_ctrl.sv
// Directed bench for ysyx_22040175_pipe_ctrl with an expectation queue.
// Counter width is shrunk so saturation is reachable in a few cycles.
module tb_ysyx_22040175_pipe_ctrl;

    localparam int CW = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  id_rd;
    logic        id_wen;
    logic        id_is_load;
    logic        ex_redirect;
    logic [63:0] ex_target;
    logic        mem_busy;
    logic        pc_hold;
    logic        if_id_hold;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        pc_sel;
    logic [63:0] redirect_pc;
    logic [1:0]  fwd_rs1;
    logic [1:0]  fwd_rs2;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    ysyx_22040175_pipe_ctrl #(
        .NSTAGE(3), .LOAD_STAGE(1), .RADDR_W(5), .PC_W(64), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load),
        .ex_redirect(ex_redirect), .ex_target(ex_target),
        .mem_busy(mem_busy),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .pc_sel(pc_sel), .redirect_pc(redirect_pc),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        hold;
        logic        flush;
        logic        bubble;
        int          f1;
        int          f2;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
        logic [63:0] rpc;
    } exp_t;

    exp_t exp_q[$];
    int n_chk = 0;
    int n_err = 0;
    logic [CW-1:0] m_stall = '0;
    logic [CW-1:0] m_flush = '0;

    task automatic id_set(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic wen, input logic ld);
        id_valid = v; id_rs1 = rs1; id_rs1_used = u1;
        id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_wen = wen; id_is_load = ld;
    endtask

    task automatic push(input string tag, input logic h, input logic fl,
                        input logic bb, input int f1, input int f2);
        exp_t e;
        e.tag = tag; e.hold = h; e.flush = fl; e.bubble = bb;
        e.f1 = f1; e.f2 = f2; e.sc = m_stall; e.fc = m_flush;
        e.rpc = ex_target;
        exp_q.push_back(e);
    endtask

    task automatic chk();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_chk++; n_err++;
            $error("FAIL queue empty got 0 exp 1");
            return;
        end
        e = exp_q.pop_front();
        n_chk++;
        assert (pc_hold === e.hold) else begin
            n_err++; $error("FAIL %s pc_hold got %0b exp %0b", e.tag, pc_hold, e.hold);
        end
        n_chk++;
        assert (if_id_hold === e.hold) else begin
            n_err++; $error("FAIL %s if_id_hold got %0b exp %0b", e.tag, if_id_hold, e.hold);
        end
        n_chk++;
        assert (if_id_flush === e.flush) else begin
            n_err++; $error("FAIL %s if_id_flush got %0b exp %0b", e.tag, if_id_flush, e.flush);
        end
        n_chk++;
        assert (pc_sel === e.flush) else begin
            n_err++; $error("FAIL %s pc_sel got %0b exp %0b", e.tag, pc_sel, e.flush);
        end
        n_chk++;
        assert (id_ex_bubble === e.bubble) else begin
            n_err++; $error("FAIL %s bubble got %0b exp %0b", e.tag, id_ex_bubble, e.bubble);
        end
        n_chk++;
        assert (redirect_pc === e.rpc) else begin
            n_err++; $error("FAIL %s redirect_pc got %h exp %h", e.tag, redirect_pc, e.rpc);
        end
        n_chk++;
        assert (stall_cnt === e.sc) else begin
            n_err++; $error("FAIL %s stall_cnt got %0d exp %0d", e.tag, stall_cnt, e.sc);
        end
        n_chk++;
        assert (flush_cnt === e.fc) else begin
            n_err++; $error("FAIL %s flush_cnt got %0d exp %0d", e.tag, flush_cnt, e.fc);
        end
        if (e.f1 >= 0) begin
            n_chk++;
            assert (fwd_rs1 === 2'(e.f1)) else begin
                n_err++; $error("FAIL %s fwd_rs1 got %0d exp %0d", e.tag, fwd_rs1, e.f1);
            end
        end
        if (e.f2 >= 0) begin
            n_chk++;
            assert (fwd_rs2 === 2'(e.f2)) else begin
                n_err++; $error("FAIL %s fwd_rs2 got %0d exp %0d", e.tag, fwd_rs2, e.f2);
            end
        end
    endtask

    // Called at a negedge with inputs already driven; ends at the next negedge.
    task automatic cyc(input string tag, input logic h, input logic fl,
                       input logic bb, input int f1, input int f2);
        push(tag, h, fl, bb, f1, f2);
        #2;
        chk();
        if (bb && !fl && m_stall != '1) m_stall = m_stall + 1'b1;
        if (fl && m_flush != '1) m_flush = m_flush + 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        ex_redirect = 1'b0;
        ex_target = 64'h0000_0000_0000_1234;
        mem_busy = 1'b0;
        id_set(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        cyc("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        id_set(1, 0, 0, 0, 0, 5, 1, 0);
        cyc("add_x5", 0, 0, 0, 0, 0);
        id_set(1, 5, 1, 0, 0, 0, 0, 0);
        cyc("fwd_ex", 0, 0, 0, 1, 0);

        id_set(1, 0, 0, 0, 0, 6, 1, 1);
        cyc("ld_x6", 0, 0, 0, 0, 0);
        id_set(1, 6, 1, 0, 0, 0, 0, 0);
        cyc("ld_use", 1, 0, 1, -1, 0);
        cyc("ld_fwd", 0, 0, 0, 2, 0);

        id_set(1, 0, 0, 0, 0, 7, 1, 0);
        cyc("x7_old", 0, 0, 0, 0, 0);
        id_set(1, 0, 0, 0, 0, 0, 1, 0);
        cyc("x0_wr", 0, 0, 0, 0, 0);
        id_set(1, 0, 0, 0, 0, 7, 1, 0);
        cyc("x7_new", 0, 0, 0, 0, 0);
        id_set(1, 0, 1, 7, 1, 0, 0, 0);
        cyc("youngest", 0, 0, 0, 0, 1);
        id_set(1, 7, 0, 7, 1, 0, 0, 0);
        cyc("fwd_e1", 0, 0, 0, 0, 2);

        id_set(1, 0, 0, 0, 0, 9, 1, 1);
        cyc("ld_x9", 0, 0, 0, 0, 0);
        id_set(1, 9, 1, 0, 0, 0, 0, 0);
        ex_redirect = 1'b1;
        ex_target = 64'h0000_0000_8000_0100;
        cyc("redir_ovr", 0, 1, 1, -1, 0);
        id_set(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("redir_inv", 0, 0, 0, 0, 0);
        ex_redirect = 1'b0;

        id_set(1, 0, 0, 0, 0, 10, 1, 0);
        cyc("add_x10", 0, 0, 0, 0, 0);
        id_set(1, 10, 1, 0, 0, 0, 0, 0);
        ex_redirect = 1'b1;
        ex_target = 64'h0000_0000_8000_0200;
        mem_busy = 1'b1;
        cyc("busy1", 1, 0, 0, 1, 0);
        cyc("busy2", 1, 0, 0, 1, 0);
        cyc("busy3", 1, 0, 0, 1, 0);
        mem_busy = 1'b0;
        cyc("busy_redir", 0, 1, 1, 1, 0);
        ex_redirect = 1'b0;
        id_set(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("post_busy", 0, 0, 0, 0, 0);

        for (int i = 0; i < 7; i++) begin
            id_set(1, 0, 0, 0, 0, 6, 1, 1);
            cyc("sat_ld", 0, 0, 0, 0, 0);
            id_set(1, 6, 1, 0, 0, 0, 0, 0);
            cyc("sat_use", 1, 0, 1, -1, 0);
        end
        id_set(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("sat_hold", 0, 0, 0, 0, 0);

        id_set(1, 0, 0, 0, 0, 6, 1, 1);
        cyc("rst_ld", 0, 0, 0, 0, 0);
        id_set(1, 6, 1, 0, 0, 0, 0, 0);
        push("rst_pre", 1, 0, 1, -1, 0);
        #2;
        chk();
        #1;
        rst = 1'b1;
        m_stall = '0;
        m_flush = '0;
        push("rst_mid", 0, 0, 0, 0, 0);
        #1;
        chk();
        @(negedge clk);
        rst = 1'b0;
        id_set(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("after_rst", 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
